button_debouncer: RTL

- Consumes the 2-FF synchronized button level (`sync_out` of the synchronizer stage).
- Filters contact bounce and produces three outputs for the snake direction/control logic:
  - a clean level,
  - a one-cycle press pulse,
  - a one-cycle release pulse.
- One instance per button, placed directly after that button's synchronizer.

---
 rtl/button_debouncer_pkg.sv | 27 ++
 rtl/button_debouncer_if.sv | 39 +++
 rtl/button_debouncer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared types and constants for the button debouncer.
//   state_t           : FSM encoding (IDLE=0, ARMING=1, HELD=2, RELEASING=3)
//   DEF_* constants   : default timing for a 25 MHz clock
//                       (10 ms debounce, 500 ms first repeat, 200 ms repeat)
//   max2()            : helper for sizing counters at elaboration time
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ              = 25_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;      // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;        // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 5;        // 200 ms

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
// Signal bundle between a button source and the debouncer.
//   btn_in        : synchronized raw button level (1 = pressed)
//   btn_level     : debounced level
//   press_pulse   : one-cycle strobe on accepted press / auto-repeat
//   release_pulse : one-cycle strobe on accepted release
//   state_dbg     : current FSM state, for observation only
// Handshake: there is no valid/ready pair. btn_in is sampled on every rising
// clk edge; all outputs are registered and change only on rising clk edges,
// so a consumer samples them every cycle and treats pulses as single-cycle
// events.
// Modports: master drives btn_in, slave (the debouncer) drives the rest.
// -----------------------------------------------------------------------------
interface button_debouncer_if;
  import button_debouncer_pkg::*;

  logic   btn_in;
  logic   btn_level;
  logic   press_pulse;
  logic   release_pulse;
  state_t state_dbg;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  state_dbg
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output state_dbg
  );
endinterface

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Filters contact bounce on one synchronized button and produces a clean
// level plus press / release strobes for the game control logic.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : button_debouncer_if.slave (btn_in in; btn_level, press_pulse,
//           release_pulse, state_dbg out)
// Parameters:
//   DEBOUNCE_CYCLES : identical consecutive samples needed to accept a change (>=2)
//   REPEAT_DELAY    : HELD cycles before the first auto-repeat pulse (>=1)
//   REPEAT_PERIOD   : cycles between further auto-repeat pulses (>=1)
// Build option:
//   BUTTON_DEBOUNCER_AUTOREPEAT_EN : when defined, press_pulse also repeats
//   while the button stays held; otherwise no repeat logic is built.
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  button_debouncer_if.slave bus
);

  // Elaboration-time legality checks on the parameters.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rpt_fire;

  // Next-state and output decode. The counter holds the number of
  // consecutive samples seen that disagree with the accepted level, so the
  // change is taken on the edge that samples the DEBOUNCE_CYCLES-th one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.btn_in) begin
          state_d = ST_ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_ARMING: begin
        if (!bus.btn_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!bus.btn_in) begin
          state_d = ST_RELEASING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASING: begin
        if (bus.btn_in) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d | rpt_fire;
      release_q <= release_d;
    end
  end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD);

  // rpt_q counts HELD cycles since entry or since the last repeat pulse;
  // rpt_first_q selects which interval is being timed. Counting only on
  // HELD->HELD edges makes it freeze through a RELEASING excursion.
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
  logic          rpt_first_q, rpt_first_d;
  logic          held_stay;

  assign held_stay  = (state_q == ST_HELD) && bus.btn_in;
  assign rpt_inc    = rpt_q + RW'(1);
  assign rpt_target = rpt_first_q ? RPT_FIRST : RPT_NEXT;

  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (press_d || release_d) begin
      // Entering HELD from ARMING, or leaving to IDLE: restart timing.
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (held_stay) begin
      if (rpt_inc == rpt_target) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.state_dbg     = state_q;

endmodule
